// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate-generation stage.
// master: upstream/downstream environment; drives the input side and out_ready.
// slave : the imm_gen_pipe stage itself.
//   flush               drop all buffered entries
//   in_valid/in_ready   input handshake; in_instr/in_pc carry the entry
//   out_valid/out_ready output handshake; out_instr/out_pc/out_imm/out_fmt/out_illegal
//                       describe the head entry
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
// Decodes the immediate, format code and illegal-opcode flag of each accepted
// instruction and holds up to two decoded entries in FIFO order.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, empties the buffer and zeroes outputs
//   bus  imm_gen_pipe_if.slave: flush, in_* handshake, out_* handshake
// out_fmt: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SH
module imm_gen_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter bit          ZIMM_EN = 1'b1
) (
    input logic           clk,
    input logic           rst,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;
    localparam logic [2:0] FmtZ    = 3'd6;
    localparam logic [2:0] FmtSh   = 3'd7;

    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpOpImm32 = 7'b0011011;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;
    entry_t head_q, tail_q;
    entry_t dec_entry;

    logic accept, pop;
    logic load_head_new, load_tail_new, shift_tail;

    // ---------------------------------------------------------------- decode
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm_sh, imm_shw;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Size casts of signed operands sign-extend to XLEN.
    assign imm_i   = XLEN'($signed(instr[31:20]));
    assign imm_s   = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b   = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_j   = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_u   = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_z   = XLEN'(instr[19:15]);
    // RV64 shifts use a 6-bit shamt; the *W forms always use 5 bits.
    assign imm_sh  = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
    assign imm_shw = XLEN'(instr[24:20]);

    always_comb begin
        dec_fmt     = FmtNone;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OpLoad, OpJalr: begin
                dec_fmt = FmtI;
                dec_imm = imm_i;
            end
            OpMiscMem, OpOp: begin
                // Legal, no immediate reported.
            end
            OpOpImm: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_fmt = FmtSh;
                    dec_imm = imm_sh;
                end else begin
                    dec_fmt = FmtI;
                    dec_imm = imm_i;
                end
            end
            OpOpImm32: begin
                if (XLEN == 64) begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        dec_fmt = FmtSh;
                        dec_imm = imm_shw;
                    end else begin
                        dec_fmt = FmtI;
                        dec_imm = imm_i;
                    end
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpStore: begin
                dec_fmt = FmtS;
                dec_imm = imm_s;
            end
            OpBranch: begin
                dec_fmt = FmtB;
                dec_imm = imm_b;
            end
            OpJal: begin
                dec_fmt = FmtJ;
                dec_imm = imm_j;
            end
            OpLui, OpAuipc: begin
                dec_fmt = FmtU;
                dec_imm = imm_u;
            end
            OpSystem: begin
                if (ZIMM_EN && funct3[2]) begin
                    dec_fmt = FmtZ;
                    dec_imm = imm_z;
                end
            end
            // Also catches instr[1:0] != 2'b11, since every legal opcode ends in 11.
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_entry.instr   = instr;
        dec_entry.pc      = bus.in_pc;
        dec_entry.imm     = dec_imm;
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = dec_illegal;
    end

    // ------------------------------------------------------------- handshake
    // in_ready depends only on state and flush, never on out_ready.
    assign bus.in_ready  = (state_q != StTwo) && !bus.flush;
    assign bus.out_valid = (state_q != StEmpty);
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        state_d       = state_q;
        load_head_new = 1'b0;
        load_tail_new = 1'b0;
        shift_tail    = 1'b0;
        if (bus.flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d       = StOne;
                        load_head_new = 1'b1;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        load_head_new = 1'b1;
                    end else if (accept) begin
                        state_d       = StTwo;
                        load_tail_new = 1'b1;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state_d    = StOne;
                        shift_tail = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head_new) begin
                head_q <= dec_entry;
            end else if (shift_tail) begin
                head_q <= tail_q;
            end
            if (load_tail_new) begin
                tail_q <= dec_entry;
            end
        end
    end

    assign bus.out_instr   = head_q.instr;
    assign bus.out_pc      = head_q.pc;
    assign bus.out_imm     = head_q.imm;
    assign bus.out_fmt     = head_q.fmt;
    assign bus.out_illegal = head_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance, directed
// stimulus with a scoreboard queue per instance.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64)) if64 ();

    imm_gen_pipe #(.XLEN(32), .ZIMM_EN(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    imm_gen_pipe #(.XLEN(64), .ZIMM_EN(1'b1)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard monitors: a pop happens at the posedge following this negedge.
    always @(negedge clk) begin
        if (!rst && if32.out_valid && if32.out_ready && !if32.flush) begin
            if (q32.size() == 0) begin
                check("pop32_unexpected", 64'(q32.size()), 64'd1);
            end else begin
                exp_t e;
                e = q32.pop_front();
                check("o32_instr", 64'(if32.out_instr), 64'(e.instr));
                check("o32_pc", 64'(if32.out_pc), e.pc);
                check("o32_imm", 64'(if32.out_imm), e.imm);
                check("o32_fmt", 64'(if32.out_fmt), 64'(e.fmt));
                check("o32_ill", 64'(if32.out_illegal), 64'(e.ill));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if64.out_valid && if64.out_ready && !if64.flush) begin
            if (q64.size() == 0) begin
                check("pop64_unexpected", 64'(q64.size()), 64'd1);
            end else begin
                exp_t e;
                e = q64.pop_front();
                check("o64_instr", 64'(if64.out_instr), 64'(e.instr));
                check("o64_pc", if64.out_pc, e.pc);
                check("o64_imm", if64.out_imm, e.imm);
                check("o64_fmt", 64'(if64.out_fmt), 64'(e.fmt));
                check("o64_ill", 64'(if64.out_illegal), 64'(e.ill));
            end
        end
    end

    // Offer one entry and return #1 after the edge that accepts it.
    task automatic send32(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        if32.in_valid = 1'b1;
        if32.in_instr = instr;
        if32.in_pc    = pc;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (if32.in_ready) begin
                q32.push_back('{instr, 64'(pc), imm, fmt, ill});
                @(posedge clk);
                #1;
                if32.in_valid = 1'b0;
                return;
            end
        end
        check("send32_timeout", 64'(if32.in_ready), 64'd1);
        if32.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] instr, input logic [63:0] pc,
                          input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        if64.in_valid = 1'b1;
        if64.in_instr = instr;
        if64.in_pc    = pc;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (if64.in_ready) begin
                q64.push_back('{instr, pc, imm, fmt, ill});
                @(posedge clk);
                #1;
                if64.in_valid = 1'b0;
                return;
            end
        end
        check("send64_timeout", 64'(if64.in_ready), 64'd1);
        if64.in_valid = 1'b0;
    endtask

    task automatic drain(input bit is64);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((is64 ? q64.size() : q32.size()) == 0) break;
        end
        @(posedge clk);
        #1;
        check(is64 ? "drain64" : "drain32", 64'(is64 ? q64.size() : q32.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        if32.flush = 1'b0; if32.in_valid = 1'b0; if32.in_instr = '0; if32.in_pc = '0;
        if32.out_ready = 1'b0;
        if64.flush = 1'b0; if64.in_valid = 1'b0; if64.in_instr = '0; if64.in_pc = '0;
        if64.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid32", 64'(if32.out_valid), 64'd0);
        check("rst_instr32", 64'(if32.out_instr), 64'd0);
        check("rst_pc32", 64'(if32.out_pc), 64'd0);
        check("rst_imm32", 64'(if32.out_imm), 64'd0);
        check("rst_fmt32", 64'(if32.out_fmt), 64'd0);
        check("rst_ill32", 64'(if32.out_illegal), 64'd0);
        check("rst_valid64", 64'(if64.out_valid), 64'd0);
        check("rst_imm64", if64.out_imm, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready32", 64'(if32.in_ready), 64'd1);

        // XLEN=32 decode, streaming with out_ready=1
        if32.out_ready = 1'b1;
        send32(32'hFFF00093, 32'h100, 64'hFFFF_FFFF, 3'd1, 1'b0);      // addi -1
        check("latency_valid", 64'(if32.out_valid), 64'd1);
        send32(32'hFFDFF06F, 32'h104, 64'hFFFF_FFFC, 3'd5, 1'b0);      // jal -4
        send32(32'h3401D073, 32'h108, 64'h3, 3'd6, 1'b0);              // csrrwi zimm 3
        send32(32'hFE112E23, 32'h10C, 64'hFFFF_FFFC, 3'd2, 1'b0);      // sw -4
        send32(32'h00000463, 32'h110, 64'h8, 3'd3, 1'b0);              // beq +8
        send32(32'h80000037, 32'h114, 64'h8000_0000, 3'd4, 1'b0);      // lui
        send32(32'h03F01013, 32'h118, 64'h1F, 3'd7, 1'b0);             // slli, 5-bit shamt
        send32(32'h00000033, 32'h11C, 64'h0, 3'd0, 1'b0);              // add
        send32(32'h0FF0000F, 32'h120, 64'h0, 3'd0, 1'b0);              // fence
        send32(32'h00000073, 32'h124, 64'h0, 3'd0, 1'b0);              // ecall
        send32(32'h0010009B, 32'h128, 64'h0, 3'd0, 1'b1);              // addiw on RV32
        send32(32'h00000001, 32'h12C, 64'h0, 3'd0, 1'b1);              // instr[1:0]!=11
        drain(1'b0);

        // Backpressure: A, B buffered, C held upstream
        if32.out_ready = 1'b0;
        send32(32'h00100093, 32'h200, 64'h1, 3'd1, 1'b0);
        send32(32'h00200113, 32'h204, 64'h2, 3'd1, 1'b0);
        if32.in_valid = 1'b1;
        if32.in_instr = 32'h00300193;
        if32.in_pc    = 32'h208;
        @(negedge clk);
        check("full_ready", 64'(if32.in_ready), 64'd0);
        check("full_valid", 64'(if32.out_valid), 64'd1);
        check("full_head", 64'(if32.out_instr), 64'h00100093);
        @(negedge clk);
        check("hold_head", 64'(if32.out_instr), 64'h00100093);
        @(posedge clk);
        #1;
        if32.out_ready = 1'b1;
        send32(32'h00300193, 32'h208, 64'h3, 3'd1, 1'b0);
        drain(1'b0);

        // Flush while full, with a concurrent offer
        if32.out_ready = 1'b0;
        send32(32'h00100093, 32'h300, 64'h1, 3'd1, 1'b0);
        send32(32'h00200113, 32'h304, 64'h2, 3'd1, 1'b0);
        if32.in_valid = 1'b1;
        if32.in_instr = 32'h00400213;
        if32.in_pc    = 32'h308;
        if32.flush    = 1'b1;
        @(negedge clk);
        check("flush_ready", 64'(if32.in_ready), 64'd0);
        @(posedge clk);
        #1;
        if32.flush    = 1'b0;
        if32.in_valid = 1'b0;
        q32.delete();
        check("flush_valid", 64'(if32.out_valid), 64'd0);
        if32.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("flush_nocapture", 64'(if32.out_valid), 64'd0);

        // Illegal opcode, then asynchronous reset while ONE
        if32.out_ready = 1'b0;
        send32(32'h0000007F, 32'h400, 64'h0, 3'd0, 1'b1);
        check("ill_valid", 64'(if32.out_valid), 64'd1);
        check("ill_flag", 64'(if32.out_illegal), 64'd1);
        check("ill_fmt", 64'(if32.out_fmt), 64'd0);
        check("ill_imm", 64'(if32.out_imm), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(if32.out_valid), 64'd0);
        check("arst_instr", 64'(if32.out_instr), 64'd0);
        check("arst_pc", 64'(if32.out_pc), 64'd0);
        q32.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // XLEN=64 decode
        if64.out_ready = 1'b1;
        send64(32'h80000037, 64'h8000_0000_0000_1000, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        send64(32'h03F01013, 64'h8000_0000_0000_1004, 64'h3F, 3'd7, 1'b0);   // slli 63
        send64(32'h03F0101B, 64'h8000_0000_0000_1008, 64'h1F, 3'd7, 1'b0);   // slliw, 5 bits
        send64(32'h0010009B, 64'h8000_0000_0000_100C, 64'h1, 3'd1, 1'b0);    // addiw 1
        send64(32'hFFF00093, 64'h8000_0000_0000_1010, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        send64(32'hFFDFF06F, 64'h8000_0000_0000_1014, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0);
        send64(32'h3401D073, 64'h8000_0000_0000_1018, 64'h3, 3'd6, 1'b0);
        drain(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate-generation stage that sits between fetch/decode and the register-read stage. It accepts one instruction and PC per valid/ready handshake and returns the XLEN-wide immediate, a format code and an illegal-opcode flag. Compared with the combinational immediate generator it adds:
- XLEN generalisation (RV32/RV64);
- CSR zimm and shift-amount formats;
- a 2-entry skid buffer with backpressure and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. Immediates are sign-extended (zimm/shamt zero-extended) to XLEN.
ZIMM_EN, 1, 1 = decode the SYSTEM CSR-immediate forms as format Z; 0 = SYSTEM reports fmt NONE.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  drop all buffered entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept
in_instr  input  32  raw instruction
in_pc  input  XLEN  instruction PC
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts
out_instr  output  32  instruction of head entry
out_pc  output  XLEN  PC of head entry
out_imm  output  XLEN  decoded immediate
out_fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SH
out_illegal  output  1  opcode not recognised, or instr[1:0] != 2'b11

Behaviour:
Reset:
- rst asserted at any time, asynchronously: occupancy = EMPTY.
- Outputs go to out_valid=0, out_instr=0, out_pc=0, out_imm=0, out_fmt=0, out_illegal=0.
- Reset mid-transfer discards all buffered entries.

Decode (registered at the accept edge; latency 1 cycle from accept to out_valid):
- LOAD 0000011, JALR 1100111, MISC_MEM 0001111: fmt I, imm = sext(instr[31:20]). Exception: MISC_MEM reports fmt NONE, imm=0.
- OP_IMM 0010011:
  - funct3 001 or 101: fmt SH, imm = zext(instr[24:20]) when XLEN=32, zext(instr[25:20]) when XLEN=64.
  - Otherwise: fmt I.
- OP_IMM_32 0011011: legal only when XLEN=64. Same rules as OP_IMM, except shamt is always instr[24:20]. When XLEN=32 it is illegal.
- STORE 0100011: fmt S, imm = sext({instr[31:25], instr[11:7]}).
- BRANCH 1100011: fmt B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- JAL 1101111: fmt J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- LUI 0110111, AUIPC 0010111: fmt U, imm = sext({instr[31:12], 12'b0}) to XLEN.
- SYSTEM 1110011:
  - ZIMM_EN=1 and funct3[2]=1: fmt Z, imm = zext(instr[19:15]).
  - Otherwise: fmt NONE, imm 0.
- OP 0110011: fmt NONE, imm 0, legal.
- Anything else: fmt NONE, imm 0, out_illegal=1. The entry is still passed through; no trap is raised here.

Buffering and handshake (occupancy FSM EMPTY / ONE / TWO, FIFO order):
- in_ready = (occupancy != TWO) && !flush. It is independent of out_ready: no combinational path from out_ready to in_ready.
- Accept: in_valid && in_ready at the rising edge.
- Pop: out_valid && out_ready at the rising edge.
- out_valid = (occupancy != EMPTY). out_* reflect the head entry and hold stable while out_valid && !out_ready.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept && !pop -> TWO; pop && !accept -> EMPTY; accept && pop -> ONE (new entry becomes head next cycle).
  - TWO: pop -> ONE (second entry becomes head); no accept is possible.
- flush: highest priority after reset. Next state is EMPTY and any concurrent accept or pop is discarded; upstream must not treat that cycle as accepted, since in_ready=0.
- Throughput: 1 entry/cycle sustained when out_ready=1.

Test Plan:
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, fmt=1, illegal=0.
- Push 0xFFDFF06F (jal x0,-4) then 0x3401D073 (csrrwi x0,mscratch,3) back-to-back -> consecutive cycles give imm 0xFFFFFFFC fmt 5, then imm 0x00000003 fmt 6.
- XLEN=64, push 0x80000037 (lui x0,0x80000) -> out_imm=0xFFFFFFFF80000000 fmt 4. Push 0x03F01013 (slli x0,x0,63) -> imm 0x3F fmt 7.
- Hold out_ready=0 and offer 3 entries A,B,C -> A and B accepted, in_ready=0 after the second, C held upstream. Raise out_ready -> outputs A, B, C in order, with no drop or duplicate.
- Occupancy TWO, assert flush one cycle with in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, new entry not captured.
- Push 0x0000007F (opcode 1111111) -> out_illegal=1, fmt 0, imm 0. Then assert rst asynchronously while occupancy is ONE -> out_valid drops immediately without waiting for a clock edge.
